// File: rtl/raster_pkg.sv
// Shared types for the raster scan position generator.
package raster_pkg;

  // Scan controller states: waiting, walking a frame, one-cycle wind-down
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } scan_state_t;

endpackage

// File: rtl/axis_counter.sv
// Single-axis wrap counter: counts 0..max and returns to 0 after max.
module axis_counter #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         clear,
  input  logic         en,
  input  logic [W-1:0] max,
  output logic [W-1:0] count,
  output logic         at_max
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  assign count  = count_q;
  assign at_max = (count_q == max);

  // Next count: clear wins, otherwise step or wrap when enabled
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (en) begin
      if (at_max) begin
        count_d = '0;
      end else begin
        count_d = count_q + W'(1);
      end
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/raster_scan_counter.sv
// Two-dimensional (column/row) pixel position generator with frame markers,
// one-shot or free-running frame modes and geometry latched at start.
module raster_scan_counter
  import raster_pkg::*;
#(
  parameter int X_W = 10,
  parameter int Y_W = 10
) (
  input  logic           clk,
  input  logic           n_rst,
  input  logic           clear,
  input  logic           start,
  input  logic           continuous,
  input  logic           count_enable,
  input  logic [X_W-1:0] cols,
  input  logic [Y_W-1:0] rows,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           busy,
  output logic           first_px,
  output logic           line_last,
  output logic           frame_last,
  output logic           done,
  output logic           cfg_err
);

  scan_state_t    state_q, state_d;
  logic [X_W-1:0] cols_max_q, cols_max_d;
  logic [Y_W-1:0] rows_max_q, rows_max_d;
  logic           mode_q, mode_d;
  logic           done_q, done_d;
  logic           cfg_err_q, cfg_err_d;

  logic           geom_ok;
  logic           start_ok;
  logic           start_bad;
  logic           axis_clear;
  logic           col_en;
  logic           row_en;
  logic           x_at_max;
  logic           y_at_max;
  logic           frame_wrap;

  // A start is only considered while idle; zero geometry is rejected
  assign geom_ok    = (cols != '0) && (rows != '0);
  assign start_ok   = !clear && (state_q == IDLE) && start && geom_ok;
  assign start_bad  = !clear && (state_q == IDLE) && start && !geom_ok;

  // Counters restart at the origin on clear or on an accepted start
  assign axis_clear = clear || start_ok;
  assign col_en     = !clear && (state_q == SCAN) && count_enable;
  assign row_en     = col_en && x_at_max;
  assign frame_wrap = row_en && y_at_max;

  axis_counter #(.W(X_W)) u_col (
    .clk    (clk),
    .n_rst  (n_rst),
    .clear  (axis_clear),
    .en     (col_en),
    .max    (cols_max_q),
    .count  (x),
    .at_max (x_at_max)
  );

  axis_counter #(.W(Y_W)) u_row (
    .clk    (clk),
    .n_rst  (n_rst),
    .clear  (axis_clear),
    .en     (row_en),
    .max    (rows_max_q),
    .count  (y),
    .at_max (y_at_max)
  );

  // State register plus geometry latch and pulse registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      cols_max_q <= '0;
      rows_max_q <= '0;
      mode_q     <= 1'b0;
      done_q     <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cols_max_q <= cols_max_d;
      rows_max_q <= rows_max_d;
      mode_q     <= mode_d;
      done_q     <= done_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  // Next state, geometry capture and completion/error pulses
  always_comb begin
    state_d    = state_q;
    cols_max_d = cols_max_q;
    rows_max_d = rows_max_q;
    mode_d     = mode_q;
    done_d     = 1'b0;
    cfg_err_d  = 1'b0;
    if (clear) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_ok) begin
            cols_max_d = cols - X_W'(1);
            rows_max_d = rows - Y_W'(1);
            mode_d     = continuous;
            state_d    = SCAN;
          end
          cfg_err_d = start_bad;
        end
        SCAN: begin
          if (frame_wrap) begin
            done_d  = 1'b1;
            state_d = mode_q ? SCAN : DONE;
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Output decode; position markers are masked outside a scan
  always_comb begin
    busy       = (state_q == SCAN);
    first_px   = busy && (x == '0) && (y == '0);
    line_last  = busy && x_at_max;
    frame_last = line_last && y_at_max;
    done       = done_q;
    cfg_err    = cfg_err_q;
  end

endmodule
